pwm_meas: RTL and testbench

//  Multi-channel PWM capture; receive-side counterpart of the LED PWM generator in trig_ctrl.
//  - Measures active width and period of each pwm_in channel in clk cycles.
//  - Reports each completed period with a one-cycle valid strobe.
//  - Used for LED/strobe loopback checks and for external PWM/trigger inputs.

---
 rtl/pwm_meas.sv | 165 ++++++++++++++++
 tb/tb_pwm_meas.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_meas.sv
// pwm_meas: multi-channel PWM capture of active width and period, with no-edge timeout.
// Defining PWM_MEAS_GLITCH_FLT_EN adds a per-channel stability filter of FLT_LEN cycles.
module pwm_meas #(
   parameter int CH_NUM  = 6,
   parameter int CNT_W   = 32,
   parameter int FLT_LEN = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CH_NUM-1:0]       meas_en,
   input  logic [CH_NUM-1:0]       meas_polar,
   input  logic [CNT_W-1:0]        meas_timeout,
   input  logic [CH_NUM-1:0]       pwm_in,
   output logic [CH_NUM*CNT_W-1:0] meas_width,
   output logic [CH_NUM*CNT_W-1:0] meas_period,
   output logic [CH_NUM-1:0]       meas_vld,
   output logic [CH_NUM-1:0]       meas_to
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_EDGE, ST_ACT, ST_INACT} state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   logic w_to_en;
   assign w_to_en = (meas_timeout != '0);

   // FLT_LEN only shapes the filter; a non-positive value is meaningless either way.
   if (FLT_LEN < 1) begin : g_flt_len_invalid
   end

   for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic             r_sync1;
      logic             r_sync2;
      logic             r_sd;
      logic             r_pend;
      logic             r_vld;
      logic             r_to;
      logic [CNT_W-1:0] r_act;
      logic [CNT_W-1:0] r_per;
      logic [CNT_W-1:0] r_width;
      logic [CNT_W-1:0] r_period;
      state_t           r_state;
      logic             w_line;
      logic             w_s;
      logic             w_rise;
      logic             w_fall;
      logic             w_tmo;

`ifdef PWM_MEAS_GLITCH_FLT_EN
      localparam int FC_W = $clog2(FLT_LEN + 1);
      logic            r_filt;
      logic [FC_W-1:0] r_fcnt;

      // Follow the synchronized line only after it has disagreed for FLT_LEN straight cycles.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
         end else if (r_sync2 == r_filt) begin
            r_fcnt <= '0;
         end else if (r_fcnt == FC_W'(FLT_LEN - 1)) begin
            r_filt <= r_sync2;
            r_fcnt <= '0;
         end else begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end

      assign w_line = r_filt;
`else
      assign w_line = r_sync2;
`endif

      assign w_s    = w_line ^ meas_polar[gi];
      assign w_rise = w_s & ~r_sd;
      assign w_fall = ~w_s & r_sd;
      assign w_tmo  = w_to_en && (r_per == meas_timeout);

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_sd     <= 1'b0;
            r_pend   <= 1'b0;
            r_vld    <= 1'b0;
            r_to     <= 1'b0;
            r_act    <= '0;
            r_per    <= '0;
            r_width  <= '0;
            r_period <= '0;
            r_state  <= ST_IDLE;
         end else begin
            r_sync1 <= pwm_in[gi];
            r_sync2 <= r_sync1;
            r_sd    <= w_s;
            r_vld   <= r_pend;
            r_pend  <= 1'b0;
            r_to    <= 1'b0;
            if (!meas_en[gi]) begin
               r_state <= ST_IDLE;
               r_act   <= '0;
               r_per   <= '0;
            end else begin
               case (r_state)
                  ST_IDLE: begin
                     r_state <= ST_WAIT_EDGE;
                     r_act   <= '0;
                     r_per   <= '0;
                  end
                  ST_WAIT_EDGE: begin
                     if (w_rise) begin
                        r_act   <= CNT_W'(1);
                        r_per   <= CNT_W'(1);
                        r_state <= ST_ACT;
                     end
                  end
                  ST_ACT: begin
                     if (w_tmo) begin
                        r_to    <= 1'b1;
                        r_act   <= '0;
                        r_per   <= '0;
                        r_state <= ST_WAIT_EDGE;
                     end else begin
                        r_per <= sat_inc(r_per);
                        if (w_s) begin
                           r_act <= sat_inc(r_act);
                        end
                        if (w_fall) begin
                           r_state <= ST_INACT;
                        end
                     end
                  end
                  ST_INACT: begin
                     // A rise landing on the timeout compare still closes the period normally.
                     if (w_rise) begin
                        r_width  <= r_act;
                        r_period <= r_per;
                        r_pend   <= 1'b1;
                        r_act    <= CNT_W'(1);
                        r_per    <= CNT_W'(1);
                        r_state  <= ST_ACT;
                     end else if (w_tmo) begin
                        r_to    <= 1'b1;
                        r_act   <= '0;
                        r_per   <= '0;
                        r_state <= ST_WAIT_EDGE;
                     end else begin
                        r_per <= sat_inc(r_per);
                     end
                  end
                  default: r_state <= ST_IDLE;
               endcase
            end
         end
      end

      assign meas_width[gi*CNT_W +: CNT_W]  = r_width;
      assign meas_period[gi*CNT_W +: CNT_W] = r_period;
      assign meas_vld[gi]                   = r_vld;
      assign meas_to[gi]                    = r_to;
   end

endmodule

// File: tb/tb_pwm_meas.sv
// tb_pwm_meas: plays pulse trains into pwm_meas and checks every strobe against
// results computed from the pulse lengths, timeout value and input-to-strobe latency.
module tb_pwm_meas;
   localparam int NCH  = 4;
   localparam int CW   = 8;
   localparam int FLT  = 4;
`ifdef PWM_MEAS_GLITCH_FLT_EN
   localparam int LAT  = 4 + FLT;
`else
   localparam int LAT  = 4;
`endif
   localparam int SAT  = (1 << CW) - 1;
   localparam int MAXP = 12;
   localparam int MAXE = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic [NCH-1:0]    meas_en;
   logic [NCH-1:0]    meas_polar;
   logic [CW-1:0]     meas_timeout;
   logic [NCH-1:0]    pwm_in;
   logic [NCH*CW-1:0] meas_width;
   logic [NCH*CW-1:0] meas_period;
   logic [NCH-1:0]    meas_vld;
   logic [NCH-1:0]    meas_to;

   pwm_meas #(.CH_NUM(NCH), .CNT_W(CW), .FLT_LEN(FLT)) dut (
      .clk          (clk),
      .rst          (rst),
      .meas_en      (meas_en),
      .meas_polar   (meas_polar),
      .meas_timeout (meas_timeout),
      .pwm_in       (pwm_in),
      .meas_width   (meas_width),
      .meas_period  (meas_period),
      .meas_vld     (meas_vld),
      .meas_to      (meas_to)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // pulse k of a channel: active for hi cycles, inactive for lo cycles,
   // optional 2-cycle active glitch starting gl cycles into the inactive phase
   int p_hi[NCH][MAXP];
   int p_lo[NCH][MAXP];
   int p_gl[NCH][MAXP];
   int p_n[NCH];
   int p_idx[NCH];
   int p_pos[NCH];
   int p_start[NCH];

   // expected strobes, in cycle order
   int e_cyc[NCH][MAXE];
   bit e_to[NCH][MAXE];
   int e_w[NCH][MAXE];
   int e_p[NCH][MAXE];
   int e_n[NCH];
   int e_head[NCH];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > SAT) ? SAT : v;
   endfunction

   task automatic set_pulse(input int ch, input int k, input int hi, input int lo, input int gl);
      p_hi[ch][k] = hi;
      p_lo[ch][k] = lo;
      p_gl[ch][k] = gl;
   endtask

   task automatic add_ev(input int ch, input int c, input bit is_to, input int w, input int p);
      e_cyc[ch][e_n[ch]] = c;
      e_to[ch][e_n[ch]]  = is_to;
      e_w[ch][e_n[ch]]   = w;
      e_p[ch][e_n[ch]]   = p;
      e_n[ch]++;
   endtask

   // Each rise after the first closes the previous period unless it outlasted
   // the timeout, in which case a timeout strobe replaces the result.
   task automatic plan(input int ch, input int start, input int tmo);
      int  s;
      int  sprev;
      bit  armed;
      p_start[ch] = start;
      p_idx[ch]   = 0;
      p_pos[ch]   = 0;
      e_n[ch]     = 0;
      e_head[ch]  = 0;
      s     = start;
      sprev = 0;
      armed = 1'b0;
      for (int k = 0; k < p_n[ch]; k++) begin
         if (armed) begin
            if (tmo != 0 && s - sprev > tmo)
               add_ev(ch, sprev + tmo + LAT - 1, 1'b1, 0, 0);
            else
               add_ev(ch, s + LAT, 1'b0, sat(p_hi[ch][k-1]), sat(s - sprev));
         end
         armed = 1'b1;
         sprev = s;
         s     = s + p_hi[ch][k] + p_lo[ch][k];
      end
      if (armed && tmo != 0)
         add_ev(ch, sprev + tmo + LAT - 1, 1'b1, 0, 0);
   endtask

   task automatic drive_inputs();
      for (int ch = 0; ch < NCH; ch++) begin
         logic act;
         int   k;
         int   pos;
         act = 1'b0;
         if (p_idx[ch] < p_n[ch] && cyc >= p_start[ch]) begin
            k   = p_idx[ch];
            pos = p_pos[ch];
            act = (pos < p_hi[ch][k]) ||
                  (p_gl[ch][k] != 0 && pos >= p_hi[ch][k] + p_gl[ch][k] &&
                   pos < p_hi[ch][k] + p_gl[ch][k] + 2);
            if (pos + 1 == p_hi[ch][k] + p_lo[ch][k]) begin
               p_idx[ch]++;
               p_pos[ch] = 0;
            end else begin
               p_pos[ch]++;
            end
         end
         pwm_in[ch] = act ^ meas_polar[ch];
      end
   endtask

   task automatic step_cycle();
      @(posedge clk);
      #1;
      cyc++;
      drive_inputs();
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) begin
         logic ev_v;
         logic ev_t;
         ev_v = 1'b0;
         ev_t = 1'b0;
         if (e_head[ch] < e_n[ch] && e_cyc[ch][e_head[ch]] == cyc) begin
            if (e_to[ch][e_head[ch]]) ev_t = 1'b1;
            else                      ev_v = 1'b1;
         end
         if (meas_vld[ch] !== 1'b0 || ev_v)
            chk($sformatf("vld[%0d]@%0d", ch, cyc), 64'(meas_vld[ch]), 64'(ev_v));
         if (meas_to[ch] !== 1'b0 || ev_t)
            chk($sformatf("to[%0d]@%0d", ch, cyc), 64'(meas_to[ch]), 64'(ev_t));
         if (ev_v) begin
            chk($sformatf("width[%0d]@%0d", ch, cyc), 64'(meas_width[ch*CW +: CW]),
                64'(e_w[ch][e_head[ch]]));
            chk($sformatf("period[%0d]@%0d", ch, cyc), 64'(meas_period[ch*CW +: CW]),
                64'(e_p[ch][e_head[ch]]));
         end
         if (ev_v || ev_t) e_head[ch]++;
      end
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step_cycle();
   endtask

   function automatic bit busy();
      for (int ch = 0; ch < NCH; ch++)
         if (p_idx[ch] < p_n[ch] || e_head[ch] < e_n[ch]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run_done();
      int guard;
      guard = 0;
      while (busy() && guard < 6000) begin
         step_cycle();
         guard++;
      end
      if (guard >= 6000) begin
         total++;
         bad++;
         $error("FAIL run_bound: still busy after %0d cycles, expected all pulses and strobes done", guard);
      end
      step_n(10);
   endtask

   task automatic finish_step();
      meas_en = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         p_n[ch]    = 0;
         e_n[ch]    = 0;
         e_head[ch] = 0;
      end
      step_n(4);
   endtask

   task automatic rand_train(input int ch, input int n);
      for (int k = 0; k < n; k++)
         set_pulse(ch, k, $urandom_range(5, 70), $urandom_range(5, 70), 0);
      p_n[ch] = n;
   endtask

   initial begin
      int s0;
      int tmo;

      rst          = 1'b1;
      meas_en      = '0;
      meas_polar   = '0;
      meas_timeout = '0;
      pwm_in       = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         p_n[ch]     = 0;
         p_idx[ch]   = 0;
         p_pos[ch]   = 0;
         p_start[ch] = 0;
         e_n[ch]     = 0;
         e_head[ch]  = 0;
      end

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset_width",  64'(meas_width),  64'd0);
      chk("reset_period", 64'(meas_period), 64'd0);
      chk("reset_vld",    64'(meas_vld),    64'd0);
      chk("reset_to",     64'(meas_to),     64'd0);
      @(negedge clk);
      rst = 1'b0;
      step_n(3);

      // generator loopback on ch0 (toggle 25, wrap 99) plus random trains elsewhere
      meas_en = '1;
      for (int k = 0; k < 5; k++) set_pulse(0, k, 25, 75, 0);
      p_n[0] = 5;
      for (int ch = 1; ch < NCH; ch++) rand_train(ch, 6);
      for (int ch = 0; ch < NCH; ch++) plan(ch, cyc + 5, 0);
      run_done();
      finish_step();

      // active-low input, 10 low / 30 high, timeout equal to the period
      meas_polar[2] = 1'b1;
      step_n(4);
      meas_timeout = CW'(40);
      meas_en      = 4'b0100;
      for (int k = 0; k < 5; k++) set_pulse(2, k, 10, 30, 0);
      p_n[2] = 5;
      plan(2, cyc + 5, 40);
      run_done();
      chk("polar_hold_width",  64'(meas_width[2*CW +: CW]),  64'd10);
      chk("polar_hold_period", 64'(meas_period[2*CW +: CW]), 64'd40);
      finish_step();
      meas_polar   = '0;
      meas_timeout = '0;
      step_n(4);

      // timeout: long active phase, then a regular train
      meas_timeout = CW'(50);
      meas_en      = 4'b0001;
      set_pulse(0, 0, 130, 10, 0);
      for (int k = 1; k < 4; k++) set_pulse(0, k, 20, 30, 0);
      p_n[0] = 4;
      plan(0, cyc + 5, 50);
      run_done();
      finish_step();
      meas_timeout = '0;

      // disable during the active phase, then re-enable
      meas_en = 4'b0010;
      for (int k = 0; k < 4; k++) set_pulse(1, k, 20, 30, 0);
      p_n[1] = 4;
      s0 = cyc + 5;
      plan(1, s0, 0);
      while (cyc < s0 + 160) step_cycle();
      meas_en[1] = 1'b0;
      e_head[1]  = e_n[1];
      step_n(60);
      chk("disable_hold_width",  64'(meas_width[1*CW +: CW]),  64'd20);
      chk("disable_hold_period", 64'(meas_period[1*CW +: CW]), 64'd50);
      for (int k = 0; k < 2; k++) set_pulse(1, k, 15, 35, 0);
      p_n[1]     = 2;
      meas_en[1] = 1'b1;
      plan(1, cyc + 5, 0);
      run_done();
      finish_step();

      // counter saturation
      meas_en = 4'b0001;
      set_pulse(0, 0, 300, 20, 0);
      set_pulse(0, 1, 10, 300, 0);
      set_pulse(0, 2, 5, 5, 0);
      p_n[0] = 3;
      plan(0, cyc + 5, 0);
      run_done();
      finish_step();

      // all channels random with a random shared timeout
      tmo          = $urandom_range(40, 150);
      meas_timeout = CW'(tmo);
      meas_en      = '1;
      for (int ch = 0; ch < NCH; ch++) begin
         rand_train(ch, 7);
         plan(ch, cyc + 5, tmo);
      end
      run_done();
      finish_step();
      meas_timeout = '0;

      // asynchronous reset in the middle of a measurement
      meas_en = 4'b1000;
      for (int k = 0; k < 8; k++) set_pulse(3, k, 20, 30, 0);
      p_n[3] = 8;
      s0 = cyc + 5;
      plan(3, s0, 0);
      while (cyc < s0 + 150) step_cycle();
      p_n[3]    = 0;
      e_head[3] = e_n[3];
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("midreset_width",  64'(meas_width),  64'd0);
      chk("midreset_period", 64'(meas_period), 64'd0);
      chk("midreset_vld",    64'(meas_vld),    64'd0);
      chk("midreset_to",     64'(meas_to),     64'd0);
      step_n(2);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) set_pulse(3, k, 12, 28, 0);
      p_n[3] = 3;
      plan(3, cyc + 5, 0);
      run_done();
      finish_step();

`ifdef PWM_MEAS_GLITCH_FLT_EN
      // 20/80 waveform with a 2-cycle glitch in each low phase
      meas_en = 4'b0010;
      for (int k = 0; k < 3; k++) set_pulse(1, k, 20, 80, 30);
      p_n[1] = 3;
      plan(1, cyc + 5, 0);
      run_done();
      chk("glitch_width",  64'(meas_width[1*CW +: CW]),  64'd20);
      chk("glitch_period", 64'(meas_period[1*CW +: CW]), 64'd100);
      finish_step();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
